// File: rtl/mem_bridge.sv
// ============================================================================
// mem_bridge : CPU memory-stage to single-request external memory bridge
//              with wait-state timeout and a sticky error flag.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module mem_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  input  logic        memwriteM,
  input  logic        memreadM,
  output logic [31:0] readdataM,
  output logic        stallM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        err
);

  localparam logic [7:0]  C_CNT_LAST = 8'(TIMEOUT - 1);
  localparam logic [31:0] C_TO_DATA  = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        w_access;
  logic        w_misaligned;

  assign w_access     = memwriteM | memreadM;
  assign w_misaligned = (aluoutM[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_access) begin
            // Store wins when both requests are raised together.
            mem_addr_q  <= {aluoutM[31:2], 2'b00};
            mem_wdata_q <= writedataM;
            mem_we_q    <= memwriteM;
            mem_req_q   <= 1'b1;
            cnt_q       <= 8'd0;
            state_q     <= S_WAIT;
            if (w_misaligned) begin
              err_q <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (mem_ack) begin
            if (!mem_we_q) begin
              rdata_q <= mem_rdata;
            end
            mem_req_q <= 1'b0;
            cnt_q     <= 8'd0;
            state_q   <= S_DONE;
          end else if (cnt_q == C_CNT_LAST) begin
            if (!mem_we_q) begin
              rdata_q <= C_TO_DATA;
            end
            mem_req_q <= 1'b0;
            cnt_q     <= 8'd0;
            err_q     <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Reset forces the stall decision to see IDLE, never DONE.
  assign stallM    = w_access & (reset | (state_q != S_DONE));
  assign readdataM = rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_bridge.sv
// ============================================================================
// tb_mem_bridge : directed scenarios plus randomized transactions against a
//                 transaction-level model of mem_bridge.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_mem_bridge;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] aluoutM;
  logic [31:0] writedataM;
  logic        memwriteM;
  logic        memreadM;
  logic [31:0] readdataM;
  logic        stallM;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        err;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_rdata;
  logic        exp_err;

  mem_bridge #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .aluoutM    (aluoutM),
    .writedataM (writedataM),
    .memwriteM  (memwriteM),
    .memreadM   (memreadM),
    .readdataM  (readdataM),
    .stallM     (stallM),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic drop_access();
    memreadM  = 1'b0;
    memwriteM = 1'b0;
  endtask

  // Reset the DUT and the model; access is held high during reset to see stallM.
  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    memreadM = 1'b1;
    mem_ack  = 1'b0;
    #1;
    check_eq("rst_stall", {31'd0, stallM}, 32'd1);
    @(negedge clk);
    drop_access();
    #1;
    check_eq("rst_req",   {31'd0, mem_req}, 32'd0);
    check_eq("rst_we",    {31'd0, mem_we},  32'd0);
    check_eq("rst_addr",  mem_addr,  32'd0);
    check_eq("rst_wdata", mem_wdata, 32'd0);
    check_eq("rst_rdata", readdataM, 32'd0);
    check_eq("rst_err",   {31'd0, err}, 32'd0);
    reset     = 1'b0;
    exp_rdata = 32'd0;
    exp_err   = 1'b0;
  endtask

  task automatic idle_gap();
    @(negedge clk);
    drop_access();
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    #1;
    check_eq("gap_stall", {31'd0, stallM},  32'd0);
    check_eq("gap_req",   {31'd0, mem_req}, 32'd0);
    check_eq("gap_rdata", readdataM, exp_rdata);
    check_eq("gap_err",   {31'd0, err}, {31'd0, exp_err});
  endtask

  // One access: IDLE cycle, WAIT cycles, then the DONE cycle. ack_n=0 means no ack.
  task automatic do_txn(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input int ack_n, input logic [31:0] rdat);
    logic        is_wr;
    logic [31:0] exp_addr;
    int          stalls;
    int          wait_cycles;
    bit          acked;
    is_wr    = wr;
    exp_addr = {addr[31:2], 2'b00};
    @(negedge clk);
    memreadM   = rd;
    memwriteM  = wr;
    aluoutM    = addr;
    writedataM = wd;
    mem_ack    = 1'($urandom_range(0, 1));
    mem_rdata  = $urandom;
    #1;
    check_eq("idle_stall", {31'd0, stallM},  32'd1);
    check_eq("idle_req",   {31'd0, mem_req}, 32'd0);
    stalls      = int'(stallM);
    acked       = 1'b0;
    wait_cycles = 0;
    if (addr[1:0] != 2'b00) exp_err = 1'b1;
    for (int k = 1; k <= TO && !acked; k++) begin
      @(negedge clk);
      mem_ack   = (k == ack_n);
      mem_rdata = (k == ack_n) ? rdat : $urandom;
      #1;
      check_eq("wait_req",   {31'd0, mem_req}, 32'd1);
      check_eq("wait_we",    {31'd0, mem_we},  {31'd0, is_wr});
      check_eq("wait_addr",  mem_addr,  exp_addr);
      check_eq("wait_wdata", mem_wdata, wd);
      check_eq("wait_rdata", readdataM, exp_rdata);
      check_eq("wait_err",   {31'd0, err}, {31'd0, exp_err});
      stalls      += int'(stallM);
      wait_cycles += int'(mem_req);
      if (k == ack_n) acked = 1'b1;
    end
    if (acked) begin
      if (!is_wr) exp_rdata = rdat;
    end else begin
      if (!is_wr) exp_rdata = 32'hDEADBEEF;
      exp_err = 1'b1;
    end
    @(negedge clk);
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    #1;
    check_eq("done_stall", {31'd0, stallM},  32'd0);
    check_eq("done_req",   {31'd0, mem_req}, 32'd0);
    check_eq("done_rdata", readdataM, exp_rdata);
    check_eq("done_err",   {31'd0, err}, {31'd0, exp_err});
    check_eq("stall_cycles", 32'(stalls), 32'((acked ? ack_n : TO) + 1));
    check_eq("req_cycles",   32'(wait_cycles), 32'(acked ? ack_n : TO));
    drop_access();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    int          sel;
    reset      = 1'b1;
    aluoutM    = 32'd0;
    writedataM = 32'd0;
    memwriteM  = 1'b0;
    memreadM   = 1'b0;
    mem_ack    = 1'b0;
    mem_rdata  = 32'd0;
    exp_rdata  = 32'd0;
    exp_err    = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();

    do_txn(1'b1, 1'b0, 32'h0000_0104, 32'h0, 1, 32'h1234_5678);
    do_txn(1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 3, 32'hFFFF_0000);
    idle_gap();
    do_txn(1'b1, 1'b0, 32'h0000_0300, 32'h0, 1, 32'hA5A5_0001);
    do_txn(1'b1, 1'b0, 32'h0000_0304, 32'h0, 1, 32'h5A5A_0002);
    check_eq("b2b_last", readdataM, 32'h5A5A_0002);

    do_txn(1'b1, 1'b1, 32'h0000_0007, 32'h1111_2222, 2, 32'h0BAD_0BAD);
    check_eq("misalign_err", {31'd0, err}, 32'd1);
    do_reset();

    do_txn(1'b1, 1'b0, 32'h0000_0500, 32'h0, 0, 32'h0);
    idle_gap();
    check_eq("timeout_sticky", {31'd0, err}, 32'd1);
    do_reset();

    // Reset during the 2nd WAIT cycle, then a late ack.
    @(negedge clk);
    memreadM = 1'b1;
    aluoutM  = 32'h0000_0040;
    mem_ack  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("rstw_req_before", {31'd0, mem_req}, 32'd1);
    @(negedge clk);
    reset     = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'h55AA_55AA;
    #1;
    check_eq("rstw_req",   {31'd0, mem_req}, 32'd0);
    check_eq("rstw_rdata", readdataM, 32'd0);
    check_eq("rstw_stall", {31'd0, stallM}, 32'd1);
    check_eq("rstw_err",   {31'd0, err}, 32'd0);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check_eq("rstw_late_rdata", readdataM, 32'd0);
    do_reset();

    for (int t = 0; t < 150; t++) begin
      a   = $urandom;
      sel = $urandom_range(0, 2);
      if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      if ($urandom_range(0, 3) == 0) idle_gap();
      do_txn(sel != 1, sel != 0, a, $urandom, $urandom_range(0, TO), $urandom);
      if (t == 75) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
